mem_fill_sched: RTL
===================

// Module: mem_fill_sched
// PURPOSE
// Loads the matrix-vector engine's nine input FIFOs from memory.
// - Fetches one 64-bit word per FIFO row over an Avalon-MM read master.
// - Unpacks each word into 8 bytes, one-hot steered: rows 0-7 are matrix rows, row 8 is the vector.
// - Sits between the top-level FSM (fill/clr, fill_done/memory_busy) and the FIFO write ports.
// PARAMETERS
// DATA_W     8   byte width written to each FIFO
// BYTES_PW   8   bytes per memory word (word width = DATA_W*BYTES_PW = 64)
// NUM_FIFOS  9   FIFOs filled per pass (8 matrix + 1 vector)
// ADDR_W     4   memory word-address width
// BASE_ADDR  0   word address of row 0; row r is read from BASE_ADDR+r
// PORTS
// clk                in   1          system clock, rising edge
// rst_n              in   1          async active-low reset
// fill               in   1          start pulse; honoured only in IDLE or DONE
// clr                in   1          synchronous abort/clear, returns to IDLE
// mem_address        out  ADDR_W     word address of current request
// mem_read           out  1          read request, held until accepted
// mem_waitrequest    in   1          slave stall; request accepted when read & !waitrequest
// mem_readdata       in   64         read response data
// mem_readdatavalid  in   1          response strobe, latency >= 1 cycle after accept
// fifo_full          in   NUM_FIFOS  per-FIFO full flags (backpressure)
// fifo_addr          out  NUM_FIFOS  one-hot FIFO select (bit r = row r)
// fifo_din           out  DATA_W     byte to write
// en_fifo_write      out  1          write strobe to the FIFO selected by fifo_addr
// memory_busy        out  1          high in REQ/WAIT/UNPACK, or while a response is outstanding
// fill_done          out  1          high in DONE (all 72 bytes written)
// BEHAVIOUR
// - Reset:
//   - state=IDLE, row=0, all outputs 0, word register 0, outstanding=0.
// - IDLE:
//   - fill & !outstanding -> REQ, row=0.
//   - Otherwise stay in IDLE.
// - REQ:
//   - mem_read=1; mem_address=BASE_ADDR+row.
//   - Address and read held stable while waitrequest=1.
//   - On accept -> WAIT, and set outstanding.
// - WAIT:
//   - On readdatavalid: capture readdata into the word register, clear outstanding -> UNPACK, byte index=0.
// - UNPACK:
//   - fifo_din = word[7:0]; fifo_addr = 1<<row.
//   - en_fifo_write = !fifo_full[row] (combinational on fifo_full).
//   - On each write: shift the word right 8 and increment the byte index. Byte 0 (LSB) is written first.
//   - fifo_full[row]=1: stall with no write; word and index held.
//   - After byte 7 is written: if row==NUM_FIFOS-1 -> DONE, else row++ -> REQ.
// - DONE:
//   - fill_done=1.
//   - fill -> REQ with row=0 (refill).
//   - clr -> IDLE.
// - clr in any state -> IDLE next cycle, row=0, no write in that cycle; clr has priority over fill.
// - Outstanding read at clr:
//   - memory_busy stays 1 and fill is ignored until the stale readdatavalid arrives.
//   - That response is discarded and never written to a FIFO.
// - readdatavalid with no outstanding request: ignored.
// - mem_read, mem_address, fifo_addr and memory_busy are decoded from registered state only.
//   en_fifo_write is the only output that depends on an input.
// - Timing (latency 1, no stalls):
//   - mem_read rises the cycle after fill is sampled.
//   - Each row takes 10 cycles: REQ 1, WAIT 1, UNPACK 8.
//   - fill_done rises 90 cycles after the first mem_read cycle.
// - Byte index is 3 bits; row counter is $clog2(NUM_FIFOS) bits; neither wraps within a pass.
// STRUCTURE
// - matvec_pkg holds:
//   - the state enum {IDLE, REQ, WAIT, UNPACK, DONE};
//   - the constants NUM_FIFOS=9, BYTES_PW=8 and DATA_W=8, shared with the top FSM and FIFO array.
// - Single module, no sub-modules.
//   Contents: state register, row counter, byte counter, 64-bit word shift register, outstanding flag.
// TESTING
// 1. Reset mid-UNPACK (row 3, byte 5) -> all outputs 0 immediately; next fill restarts at address 0.
// 2. Memory word r = 64'h(r)7_..._(r)0, latency 1, no stalls, fill pulse:
//    - exactly 72 writes; row r gets bytes 0xr0..0xr7 in order;
//    - fill_done at cycle 90.
// 3. waitrequest=1 for 4 cycles on the row-2 request -> address 2 and mem_read held stable; data correct.
// 4. fifo_full[5]=1 for 3 cycles during UNPACK of row 5 -> no writes, byte held; then resumes with no byte lost or duplicated.
// 5. clr in WAIT with the response arriving 3 cycles later:
//    - fill during that gap is ignored; stale data is not written;
//    - fill after the drain starts cleanly at row 0.
// 6. fill while busy -> ignored. fill in DONE -> second full pass, fill_done drops. fill+clr together -> IDLE.

Source files
------------

// File: rtl/matvec_pkg.sv
// Shared types and sizing constants for the matrix-vector engine.
// The top FSM, the FIFO array and the memory fill scheduler all import this package.
package matvec_pkg;

   localparam int NUM_FIFOS = 9;
   localparam int BYTES_PW  = 8;
   localparam int DATA_W    = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ    = 3'd1,
      WAIT   = 3'd2,
      UNPACK = 3'd3,
      DONE   = 3'd4
   } state_t;

endpackage

// File: rtl/mem_fill_sched.sv
// Fills the nine matrix-vector input FIFOs from memory: one 64-bit Avalon-MM read per row,
// then eight byte writes (LSB first) steered one-hot to that row's FIFO.
module mem_fill_sched #(
   parameter int DATA_W    = 8,
   parameter int BYTES_PW  = 8,
   parameter int NUM_FIFOS = 9,
   parameter int ADDR_W    = 4,
   parameter int BASE_ADDR = 0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        fill,
   input  logic                        clr,
   output logic [ADDR_W-1:0]           mem_address,
   output logic                        mem_read,
   input  logic                        mem_waitrequest,
   input  logic [DATA_W*BYTES_PW-1:0]  mem_readdata,
   input  logic                        mem_readdatavalid,
   input  logic [NUM_FIFOS-1:0]        fifo_full,
   output logic [NUM_FIFOS-1:0]        fifo_addr,
   output logic [DATA_W-1:0]           fifo_din,
   output logic                        en_fifo_write,
   output logic                        memory_busy,
   output logic                        fill_done
);

   import matvec_pkg::*;

   localparam int WORD_W = DATA_W * BYTES_PW;
   localparam int ROW_W  = $clog2(NUM_FIFOS);
   localparam int BYTE_W = $clog2(BYTES_PW);

   // Handshake: a read is accepted in any cycle where mem_read && !mem_waitrequest;
   // exactly one response (mem_readdatavalid) follows at least one cycle later.
   // A FIFO byte is transferred in any cycle where en_fifo_write is high.

   state_t              state;
   logic [ROW_W-1:0]    row;
   logic [BYTE_W-1:0]   byte_idx;
   logic [WORD_W-1:0]   word;
   logic                outstanding;

   logic                in_req;
   logic                in_unpack;
   logic                accept;
   logic                row_full;
   logic                last_byte;
   logic                last_row;

   assign in_req    = (state == REQ);
   assign in_unpack = (state == UNPACK);
   assign accept    = in_req && !mem_waitrequest;
   assign row_full  = fifo_full[row];
   assign last_byte = (byte_idx == BYTE_W'(BYTES_PW - 1));
   assign last_row  = (row == ROW_W'(NUM_FIFOS - 1));

   assign mem_read      = in_req;
   assign mem_address   = in_req ? (ADDR_W'(BASE_ADDR) + ADDR_W'(row)) : '0;
   assign fifo_addr     = in_unpack ? (NUM_FIFOS'(1) << row) : '0;
   assign fifo_din      = in_unpack ? word[DATA_W-1:0] : '0;
   assign en_fifo_write = in_unpack && !row_full && !clr;
   assign memory_busy   = in_req || (state == WAIT) || in_unpack || outstanding;
   assign fill_done     = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         row         <= '0;
         byte_idx    <= '0;
         word        <= '0;
         outstanding <= 1'b0;
      end else begin
         // Tracks the bus independently of the FSM so an aborted read is still drained.
         if (accept) begin
            outstanding <= 1'b1;
         end else if (mem_readdatavalid) begin
            outstanding <= 1'b0;
         end

         if (clr) begin
            state    <= IDLE;
            row      <= '0;
            byte_idx <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (fill && !outstanding) begin
                     state <= REQ;
                     row   <= '0;
                  end
               end
               REQ: begin
                  if (!mem_waitrequest) begin
                     state <= WAIT;
                  end
               end
               WAIT: begin
                  if (mem_readdatavalid && outstanding) begin
                     word     <= mem_readdata;
                     byte_idx <= '0;
                     state    <= UNPACK;
                  end
               end
               UNPACK: begin
                  if (!row_full) begin
                     word     <= word >> DATA_W;
                     byte_idx <= byte_idx + BYTE_W'(1);
                     if (last_byte) begin
                        if (last_row) begin
                           state <= DONE;
                        end else begin
                           row   <= row + ROW_W'(1);
                           state <= REQ;
                        end
                     end
                  end
               end
               DONE: begin
                  if (fill) begin
                     state <= REQ;
                     row   <= '0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
